// File: rtl/loq_pkg.sv
// Shared types and helpers for the load-ordering queue.
// Optional macro LOQ_BYTEMASK_EN enables byte-mask overlap in the violation check.
package loq_pkg;

   localparam int SQN_W  = 7;
   localparam int LSQN_W = 7;
   localparam int ADDR_W = 30;

   typedef logic [SQN_W-1:0]  SqN_t;
   typedef logic [LSQN_W-1:0] LSqN_t;

   typedef struct packed {
      logic              valid;
      SqN_t              sqN;
      logic [ADDR_W-1:0] addr;
      logic [3:0]        mask;
   } loq_entry_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      SqN_t        sqN;
   } redirect_t;

   // a is younger than b when the wrapped difference is strictly positive
   function automatic logic sqn_younger(input SqN_t a, input SqN_t b);
      SqN_t d;
      d = a - b;
      return (!d[SQN_W-1]) && (d != '0);
   endfunction

   function automatic logic loq_overlap(input logic [ADDR_W-1:0] ld_addr, input logic [3:0] ld_mask,
                                        input logic [ADDR_W-1:0] st_addr, input logic [3:0] st_mask);
`ifdef LOQ_BYTEMASK_EN
      return (ld_addr == st_addr) && ((ld_mask & st_mask) != 4'h0);
`else
      // the mask term is absorbed: word equality alone is a hit
      return (ld_addr == st_addr) || ((ld_addr == st_addr) && ((ld_mask & st_mask) != 4'h0));
`endif
   endfunction

endpackage

// File: rtl/loq_age_select.sv
// Picks the oldest valid requester among N store ports; ties keep the lowest port.
module loq_age_select
   import loq_pkg::*;
#(
   parameter int N     = 2,
   parameter int SEL_W = 1
) (
   input  logic [N-1:0]       i_valid,
   input  logic [N*SQN_W-1:0] i_sqN,
   output logic [SEL_W-1:0]   o_sel,
   output logic               o_any
);

   SqN_t w_best;
   logic w_take;

   always_comb begin
      o_sel  = '0;
      o_any  = 1'b0;
      w_best = '0;
      w_take = 1'b0;
      for (int s = 0; s < N; s++) begin
         w_take = i_valid[s] && (!o_any || sqn_younger(w_best, i_sqN[s*SQN_W +: SQN_W]));
         o_sel  = w_take ? SEL_W'(s) : o_sel;
         w_best = w_take ? i_sqN[s*SQN_W +: SQN_W] : w_best;
         o_any  = o_any | w_take;
      end
   end

endmodule

// File: rtl/load_order_queue.sv
// Circular load-ordering queue with store->load violation detection and registered redirect.
// Optional macro LOQ_BYTEMASK_EN: byte-mask overlap instead of word-address-only matching.
module load_order_queue
   import loq_pkg::*;
#(
   parameter int NUM_LD = 2,
   parameter int NUM_ST = 2,
   parameter int DEPTH  = 32,
   parameter int DEQ_W  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [SQN_W-1:0]           IN_commitSqN,
   input  logic [NUM_LD-1:0]          IN_ldValid,
   input  logic [NUM_LD*SQN_W-1:0]    IN_ldSqN,
   input  logic [NUM_LD*LSQN_W-1:0]   IN_ldLSqN,
   input  logic [NUM_LD*ADDR_W-1:0]   IN_ldAddr,
   input  logic [NUM_LD*4-1:0]        IN_ldMask,
   input  logic [NUM_ST-1:0]          IN_stValid,
   input  logic [NUM_ST*SQN_W-1:0]    IN_stSqN,
   input  logic [NUM_ST*ADDR_W-1:0]   IN_stAddr,
   input  logic [NUM_ST*4-1:0]        IN_stMask,
   input  logic [NUM_ST*32-1:0]       IN_stPC,
   input  logic [NUM_ST-1:0]          IN_stCompr,
   input  logic                       IN_brValid,
   input  logic [SQN_W-1:0]           IN_brSqN,
   output logic                       OUT_rdValid,
   output logic [31:0]                OUT_rdPC,
   output logic [SQN_W-1:0]           OUT_rdSqN,
   output logic [LSQN_W-1:0]          OUT_maxLoadSqN
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEQ_W + 1);
   localparam int SEL_W = (NUM_ST > 1) ? $clog2(NUM_ST) : 1;

   loq_entry_t r_ent [DEPTH];
   LSqN_t      r_head;
   LSqN_t      r_maxLoadSqN;
   redirect_t  r_rd;

   logic [DEPTH-1:0]  w_kill;
   logic [NUM_LD-1:0] w_ldAcc;
   logic [NUM_LD-1:0] w_ldInWin;
   logic [NUM_ST-1:0] w_stAct;
   logic [NUM_ST-1:0] w_stHit;
   logic [DEQ_W-1:0]  w_deq;
   logic [CNT_W-1:0]  w_deqCnt;
   logic              w_run;
   logic [SEL_W-1:0]  w_sel;
   logic              w_anyHit;
   LSqN_t             w_headNxt;

   // flush kill mask and surviving load enqueues
   always_comb begin
      w_kill    = '0;
      w_ldAcc   = '0;
      w_ldInWin = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_kill[i] = IN_brValid && sqn_younger(r_ent[i].sqN, IN_brSqN);
      end
      for (int p = 0; p < NUM_LD; p++) begin
         w_ldAcc[p]   = IN_ldValid[p] && !(IN_brValid && sqn_younger(IN_ldSqN[p*SQN_W +: SQN_W], IN_brSqN));
         w_ldInWin[p] = LSqN_t'(IN_ldLSqN[p*LSQN_W +: LSQN_W] - r_head) < LSqN_t'(DEPTH);
      end
   end

   // per-store violation search over stored entries and same-cycle enqueues
   always_comb begin
      w_stAct = '0;
      w_stHit = '0;
      for (int s = 0; s < NUM_ST; s++) begin
         w_stAct[s] = IN_stValid[s] && !(IN_brValid && sqn_younger(IN_stSqN[s*SQN_W +: SQN_W], IN_brSqN));
         for (int i = 0; i < DEPTH; i++) begin
            w_stHit[s] = w_stHit[s] | (w_stAct[s] && r_ent[i].valid && !w_kill[i]
                         && sqn_younger(r_ent[i].sqN, IN_stSqN[s*SQN_W +: SQN_W])
                         && loq_overlap(r_ent[i].addr, r_ent[i].mask,
                                        IN_stAddr[s*ADDR_W +: ADDR_W], IN_stMask[s*4 +: 4]));
         end
         for (int p = 0; p < NUM_LD; p++) begin
            w_stHit[s] = w_stHit[s] | (w_stAct[s] && w_ldAcc[p]
                         && sqn_younger(IN_ldSqN[p*SQN_W +: SQN_W], IN_stSqN[s*SQN_W +: SQN_W])
                         && loq_overlap(IN_ldAddr[p*ADDR_W +: ADDR_W], IN_ldMask[p*4 +: 4],
                                        IN_stAddr[s*ADDR_W +: ADDR_W], IN_stMask[s*4 +: 4]));
         end
      end
   end

   // in-order retirement from head, halted at the first non-retirable slot
   always_comb begin
      w_deq    = '0;
      w_deqCnt = '0;
      w_run    = !IN_brValid;
      for (int d = 0; d < DEQ_W; d++) begin
         if (w_run && r_ent[r_head[IDX_W-1:0] + IDX_W'(d)].valid
             && sqn_younger(IN_commitSqN, r_ent[r_head[IDX_W-1:0] + IDX_W'(d)].sqN)) begin
            w_deq[d] = 1'b1;
            w_deqCnt = w_deqCnt + CNT_W'(1);
         end else begin
            w_run = 1'b0;
         end
      end
      w_headNxt = r_head + LSqN_t'(w_deqCnt);
   end

   loq_age_select #(
      .N     (NUM_ST),
      .SEL_W (SEL_W)
   ) u_age_select (
      .i_valid (w_stHit),
      .i_sqN   (IN_stSqN),
      .o_sel   (w_sel),
      .o_any   (w_anyHit)
   );

   // queue state, head pointer and redirect register
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_ent[i] <= '0;
         end
         r_head       <= '0;
         r_maxLoadSqN <= LSqN_t'(DEPTH - 1);
         r_rd         <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_kill[i]) r_ent[i].valid <= 1'b0;
         end
         for (int d = 0; d < DEQ_W; d++) begin
            if (w_deq[d]) r_ent[r_head[IDX_W-1:0] + IDX_W'(d)].valid <= 1'b0;
         end
         for (int p = 0; p < NUM_LD; p++) begin
            if (w_ldAcc[p]) begin
               r_ent[IN_ldLSqN[p*LSQN_W +: IDX_W]] <= '{valid: 1'b1,
                                                        sqN:   IN_ldSqN[p*SQN_W +: SQN_W],
                                                        addr:  IN_ldAddr[p*ADDR_W +: ADDR_W],
                                                        mask:  IN_ldMask[p*4 +: 4]};
            end
         end
         r_head       <= w_headNxt;
         r_maxLoadSqN <= w_headNxt + LSqN_t'(DEPTH - 1);
         r_rd.valid   <= w_anyHit;
         if (w_anyHit) begin
            r_rd.pc  <= IN_stPC[w_sel*32 +: 32] + (IN_stCompr[w_sel] ? 32'd2 : 32'd4);
            r_rd.sqN <= IN_stSqN[w_sel*SQN_W +: SQN_W];
         end
      end
   end

   // loads must land inside [head, maxLoadSqN]; upstream guarantees it
   a_ld_in_window : assert property (@(posedge clk) disable iff (rst) (IN_ldValid & ~w_ldInWin) == '0);

   assign OUT_rdValid    = r_rd.valid;
   assign OUT_rdPC       = r_rd.pc;
   assign OUT_rdSqN      = r_rd.sqN;
   assign OUT_maxLoadSqN = r_maxLoadSqN;

endmodule

// File: tb/tb_load_order_queue.sv
// Self-checking bench for load_order_queue: directed scenarios plus randomized traffic vs a behavioural model.
module tb_load_order_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  commit_sqn;
   logic [1:0]  ld_v;
   logic [6:0]  ld_sqn [2];
   logic [6:0]  ld_lsqn [2];
   logic [29:0] ld_addr [2];
   logic [3:0]  ld_mask [2];
   logic [1:0]  st_v;
   logic [6:0]  st_sqn [2];
   logic [29:0] st_addr [2];
   logic [3:0]  st_mask [2];
   logic [31:0] st_pc [2];
   logic [1:0]  st_compr;
   logic        br_v;
   logic [6:0]  br_sqn;

   logic        OUT_rdValid;
   logic [31:0] OUT_rdPC;
   logic [6:0]  OUT_rdSqN;
   logic [6:0]  OUT_maxLoadSqN;

   // behavioural model: slot contents by lsqn mod 32, unbounded head counter
   bit          m_valid [32];
   int          m_sqn [32];
   int          m_addr [32];
   int          m_mask [32];
   int          m_head;
   bit          exp_v;
   logic [31:0] exp_pc;
   logic [6:0]  exp_sqn;
   logic [6:0]  exp_max;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   load_order_queue dut (
      .clk            (clk),
      .rst            (rst),
      .IN_commitSqN   (commit_sqn),
      .IN_ldValid     (ld_v),
      .IN_ldSqN       ({ld_sqn[1], ld_sqn[0]}),
      .IN_ldLSqN      ({ld_lsqn[1], ld_lsqn[0]}),
      .IN_ldAddr      ({ld_addr[1], ld_addr[0]}),
      .IN_ldMask      ({ld_mask[1], ld_mask[0]}),
      .IN_stValid     (st_v),
      .IN_stSqN       ({st_sqn[1], st_sqn[0]}),
      .IN_stAddr      ({st_addr[1], st_addr[0]}),
      .IN_stMask      ({st_mask[1], st_mask[0]}),
      .IN_stPC        ({st_pc[1], st_pc[0]}),
      .IN_stCompr     (st_compr),
      .IN_brValid     (br_v),
      .IN_brSqN       (br_sqn),
      .OUT_rdValid    (OUT_rdValid),
      .OUT_rdPC       (OUT_rdPC),
      .OUT_rdSqN      (OUT_rdSqN),
      .OUT_maxLoadSqN (OUT_maxLoadSqN)
   );

   function automatic bit yng(int a, int b);
      int d;
      d = (a - b) & 127;
      return (d >= 1) && (d <= 63);
   endfunction

   function automatic bit ovl(int la, int lm, int sa, int sm);
`ifdef LOQ_BYTEMASK_EN
      return (la == sa) && ((lm & sm) != 0);
`else
      return la == sa;
`endif
   endfunction

   task automatic clear_inputs();
      ld_v = 2'b00; st_v = 2'b00; br_v = 1'b0; br_sqn = 7'd0; st_compr = 2'b00;
      for (int i = 0; i < 2; i++) begin
         ld_sqn[i] = 7'd0; ld_lsqn[i] = 7'd0; ld_addr[i] = 30'd0; ld_mask[i] = 4'hF;
         st_sqn[i] = 7'd0; st_addr[i] = 30'd0; st_mask[i] = 4'hF; st_pc[i] = 32'd0;
      end
   endtask

   // one clock: predict the redirect from pre-edge state, then advance the model
   task automatic tick();
      bit hit [2];
      int win;
      exp_v = 1'b0;
      win   = -1;
      for (int s = 0; s < 2; s++) begin
         hit[s] = 1'b0;
         if (!rst && st_v[s] && !(br_v && yng(st_sqn[s], br_sqn))) begin
            for (int i = 0; i < 32; i++)
               if (m_valid[i] && !(br_v && yng(m_sqn[i], br_sqn)) && yng(m_sqn[i], st_sqn[s])
                   && ovl(m_addr[i], m_mask[i], st_addr[s], st_mask[s])) hit[s] = 1'b1;
            for (int p = 0; p < 2; p++)
               if (ld_v[p] && !(br_v && yng(ld_sqn[p], br_sqn)) && yng(ld_sqn[p], st_sqn[s])
                   && ovl(ld_addr[p], ld_mask[p], st_addr[s], st_mask[s])) hit[s] = 1'b1;
         end
         if (hit[s] && (win < 0 || yng(st_sqn[win], st_sqn[s]))) win = s;
      end
      if (win >= 0) begin
         exp_v   = 1'b1;
         exp_sqn = st_sqn[win];
         exp_pc  = st_pc[win] + (st_compr[win] ? 32'd2 : 32'd4);
      end
      @(posedge clk);
      #1;
      if (rst) begin
         for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
         m_head = 0;
      end else begin
         if (br_v) begin
            for (int i = 0; i < 32; i++) if (yng(m_sqn[i], br_sqn)) m_valid[i] = 1'b0;
         end else begin
            for (int k = 0; k < 2; k++) begin
               if (!(m_valid[m_head % 32] && yng(commit_sqn, m_sqn[m_head % 32]))) break;
               m_valid[m_head % 32] = 1'b0;
               m_head++;
            end
         end
         for (int p = 0; p < 2; p++) begin
            if (ld_v[p] && !(br_v && yng(ld_sqn[p], br_sqn))) begin
               m_valid[ld_lsqn[p] % 32] = 1'b1;
               m_sqn[ld_lsqn[p] % 32]   = ld_sqn[p];
               m_addr[ld_lsqn[p] % 32]  = ld_addr[p];
               m_mask[ld_lsqn[p] % 32]  = ld_mask[p];
            end
         end
      end
      exp_max = 7'((m_head + 31) & 127);
      ld_v = 2'b00; st_v = 2'b00; br_v = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      commit_sqn = 7'd0;
      do_reset();
      tick();
      n_chk++; if (OUT_rdValid !== 1'b0) begin n_fail++; $display("FAIL reset_rdValid got %0b want 0", OUT_rdValid); end
      n_chk++; if (OUT_maxLoadSqN !== 7'd31) begin n_fail++; $display("FAIL reset_maxLoad got %0d want 31", OUT_maxLoadSqN); end
      st_v = 2'b01; st_sqn[0] = 7'd0; st_addr[0] = 30'd0;
      tick();
      n_chk++; if (OUT_rdValid !== 1'b0) begin n_fail++; $display("FAIL reset_empty_store got %0b want 0", OUT_rdValid); end
   endtask

   task automatic test_store_hit();
      do_reset();
      ld_v = 2'b01; ld_lsqn[0] = 7'd0; ld_sqn[0] = 7'd10; ld_addr[0] = 30'h100; ld_mask[0] = 4'hF;
      tick();
      st_v = 2'b01; st_sqn[0] = 7'd5; st_addr[0] = 30'h100; st_pc[0] = 32'h0000_8000; st_compr = 2'b00;
      tick();
      n_chk++; if (OUT_rdValid !== 1'b1) begin n_fail++; $display("FAIL hit_rdValid got %0b want 1", OUT_rdValid); end
      n_chk++; if (OUT_rdSqN !== 7'd5) begin n_fail++; $display("FAIL hit_rdSqN got %0d want 5", OUT_rdSqN); end
      n_chk++; if (OUT_rdPC !== 32'h0000_8004) begin n_fail++; $display("FAIL hit_rdPC got %h want 00008004", OUT_rdPC); end
      tick();
      n_chk++; if (OUT_rdValid !== 1'b0) begin n_fail++; $display("FAIL hit_one_cycle got %0b want 0", OUT_rdValid); end
      // compressed store, then a reset that overlaps a hitting store
      st_v = 2'b10; st_sqn[1] = 7'd3; st_addr[1] = 30'h100; st_pc[1] = 32'h0000_9000; st_compr = 2'b10;
      tick();
      n_chk++; if (OUT_rdPC !== exp_pc || exp_pc !== 32'h0000_9002) begin n_fail++; $display("FAIL hit_compr_pc got %h want 00009002", OUT_rdPC); end
      rst = 1'b1; st_v = 2'b01;
      tick();
      rst = 1'b0; st_v = 2'b01;
      tick();
      n_chk++; if (OUT_rdValid !== 1'b0) begin n_fail++; $display("FAIL midreset_clear got %0b want 0", OUT_rdValid); end
   endtask

   task automatic test_dequeue();
      do_reset();
      commit_sqn = 7'd0;
      for (int k = 0; k < 16; k++) begin
         ld_v = 2'b11;
         for (int p = 0; p < 2; p++) begin
            ld_lsqn[p] = 7'(2*k + p); ld_sqn[p] = 7'(10 + 2*k + p);
            ld_addr[p] = 30'($urandom_range(0, 1023)); ld_mask[p] = 4'hF;
         end
         tick();
         n_chk++; if (OUT_maxLoadSqN !== exp_max) begin n_fail++; $display("FAIL deq_fill_max got %0d want %0d", OUT_maxLoadSqN, exp_max); end
      end
      commit_sqn = 7'd13;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_chk++; if (OUT_maxLoadSqN !== exp_max) begin n_fail++; $display("FAIL deq_step_max got %0d want %0d", OUT_maxLoadSqN, exp_max); end
      end
      n_chk++; if (OUT_maxLoadSqN !== 7'd34) begin n_fail++; $display("FAIL deq_final_max got %0d want 34", OUT_maxLoadSqN); end
   endtask

   task automatic test_flush();
      do_reset();
      commit_sqn = 7'd0;
      for (int k = 0; k < 4; k++) begin
         ld_v = 2'b11;
         for (int p = 0; p < 2; p++) begin
            ld_lsqn[p] = 7'(2*k + p); ld_sqn[p] = 7'(18 + 2*k + p);
            ld_addr[p] = 30'(32'h200 + 2*k + p); ld_mask[p] = 4'hF;
         end
         tick();
      end
      br_v = 1'b1; br_sqn = 7'd20;
      ld_v = 2'b01; ld_lsqn[0] = 7'd8; ld_sqn[0] = 7'd26; ld_addr[0] = 30'h300;
      st_v = 2'b01; st_sqn[0] = 7'd25; st_addr[0] = 30'h300;
      tick();
      n_chk++; if (OUT_rdValid !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_rd got %0b want 0", OUT_rdValid); end
      n_chk++; if (OUT_maxLoadSqN !== 7'd31) begin n_fail++; $display("FAIL flush_head got %0d want 31", OUT_maxLoadSqN); end
      for (int a = 3; a < 8; a++) begin
         st_v = 2'b01; st_sqn[0] = 7'd19; st_addr[0] = 30'(32'h200 + a);
         tick();
         n_chk++; if (OUT_rdValid !== 1'b0) begin n_fail++; $display("FAIL flush_killed_%0d got %0b want 0", a, OUT_rdValid); end
      end
      st_v = 2'b01; st_sqn[0] = 7'd19; st_addr[0] = 30'h202;
      tick();
      n_chk++; if (OUT_rdValid !== 1'b1 || OUT_rdSqN !== 7'd19) begin n_fail++; $display("FAIL flush_survivor got %0b/%0d want 1/19", OUT_rdValid, OUT_rdSqN); end
   endtask

   task automatic test_multi_store();
      do_reset();
      ld_v = 2'b01; ld_lsqn[0] = 7'd0; ld_sqn[0] = 7'd10; ld_addr[0] = 30'h300; ld_mask[0] = 4'hF;
      tick();
      for (int swap = 0; swap < 2; swap++) begin
         st_v = 2'b11; st_compr = 2'b00;
         st_sqn[swap] = 7'd6; st_sqn[1-swap] = 7'd8;
         st_addr[0] = 30'h300; st_addr[1] = 30'h300;
         st_pc[0] = 32'h1000; st_pc[1] = 32'h2000;
         tick();
         n_chk++; if (OUT_rdValid !== 1'b1 || OUT_rdSqN !== 7'd6) begin n_fail++; $display("FAIL multi_oldest_%0d got %0b/%0d want 1/6", swap, OUT_rdValid, OUT_rdSqN); end
         n_chk++; if (OUT_rdPC !== exp_pc) begin n_fail++; $display("FAIL multi_pc_%0d got %h want %h", swap, OUT_rdPC, exp_pc); end
      end
      ld_v = 2'b10; ld_lsqn[1] = 7'd1; ld_sqn[1] = 7'd12; ld_addr[1] = 30'h400; ld_mask[1] = 4'hF;
      st_v = 2'b10; st_sqn[1] = 7'd11; st_addr[1] = 30'h400; st_pc[1] = 32'h3000;
      tick();
      n_chk++; if (OUT_rdValid !== 1'b1 || OUT_rdSqN !== 7'd11) begin n_fail++; $display("FAIL same_cycle_hit got %0b/%0d want 1/11", OUT_rdValid, OUT_rdSqN); end
   endtask

   task automatic test_bytemask();
      bit want;
`ifdef LOQ_BYTEMASK_EN
      want = 1'b0;
`else
      want = 1'b1;
`endif
      do_reset();
      ld_v = 2'b01; ld_lsqn[0] = 7'd0; ld_sqn[0] = 7'd10; ld_addr[0] = 30'h500; ld_mask[0] = 4'h3;
      tick();
      st_v = 2'b01; st_sqn[0] = 7'd5; st_addr[0] = 30'h500; st_mask[0] = 4'hC;
      tick();
      n_chk++; if (OUT_rdValid !== want) begin n_fail++; $display("FAIL mask_disjoint got %0b want %0b", OUT_rdValid, want); end
      st_v = 2'b01; st_sqn[0] = 7'd5; st_addr[0] = 30'h500; st_mask[0] = 4'h6;
      tick();
      n_chk++; if (OUT_rdValid !== 1'b1) begin n_fail++; $display("FAIL mask_overlap got %0b want 1", OUT_rdValid); end
   endtask

   task automatic test_random();
      int nl, ns, cm, lo, br;
      int gen_sqn [128];
      clear_inputs();
      do_reset();
      nl = 0; ns = 20; cm = 20;
      commit_sqn = 7'(cm);
      for (int c = 0; c < 600; c++) begin
         for (int p = 0; p < 2; p++) begin
            if ($urandom_range(0, 2) != 0 && (nl - m_head) < 32) begin
               ld_v[p] = 1'b1; ld_lsqn[p] = 7'(nl); ld_sqn[p] = 7'(ns);
               ld_addr[p] = 30'($urandom_range(0, 3)); ld_mask[p] = 4'($urandom_range(1, 15));
               gen_sqn[nl & 127] = ns;
               nl++; ns++;
            end
         end
         for (int s = 0; s < 2; s++) begin
            if ($urandom_range(0, 3) == 0) begin
               st_v[s] = 1'b1; st_sqn[s] = 7'(ns - $urandom_range(0, 20));
               st_addr[s] = 30'($urandom_range(0, 3)); st_mask[s] = 4'($urandom_range(1, 15));
               st_pc[s] = $urandom; st_compr[s] = 1'($urandom_range(0, 1));
            end
         end
         lo = (ns - 8 > cm) ? ns - 8 : cm;
         if ($urandom_range(0, 15) == 0 && lo <= ns - 1) begin
            br = $urandom_range(lo, ns - 1);
            br_v = 1'b1; br_sqn = 7'(br);
            while (nl > m_head && gen_sqn[(nl - 1) & 127] > br) nl--;
            ns = br + 1;
         end else begin
            cm = cm + $urandom_range(0, 2);
            if (cm > ns) cm = ns;
            commit_sqn = 7'(cm);
         end
         tick();
         n_chk++; if (OUT_rdValid !== exp_v) begin n_fail++; $display("FAIL rnd_rdValid cyc %0d got %0b want %0b", c, OUT_rdValid, exp_v); end
         if (exp_v) begin
            n_chk++; if (OUT_rdSqN !== exp_sqn || OUT_rdPC !== exp_pc) begin n_fail++; $display("FAIL rnd_rd cyc %0d got %0d/%h want %0d/%h", c, OUT_rdSqN, OUT_rdPC, exp_sqn, exp_pc); end
         end
         n_chk++; if (OUT_maxLoadSqN !== exp_max) begin n_fail++; $display("FAIL rnd_max cyc %0d got %0d want %0d", c, OUT_maxLoadSqN, exp_max); end
      end
   endtask

   initial begin
      rst = 1'b1;
      m_head = 0;
      test_reset();
      test_store_hit();
      test_dequeue();
      test_flush();
      test_multi_store();
      test_bytemask();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
